// File: rtl/mem_region_router_if.sv
// mem_region_router_if: CPU request port and slave access port of the region router.
interface mem_region_router_if #(
  parameter int N_REG = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic cpu_req;
  logic cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic cpu_stall;
  logic [N_REG-1:0] slv_sel;
  logic slv_we;
  logic [ADDR_W-1:0] slv_addr;
  logic [DATA_W-1:0] slv_wdata;
  logic [N_REG*DATA_W-1:0] slv_rdata;
  logic [N_REG-1:0] slv_ready;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
    input cpu_rdata, cpu_stall, slv_sel, slv_we, slv_addr, slv_wdata
  );
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
    output cpu_rdata, cpu_stall, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mem_region_router.sv
// mem_region_router: decodes CPU/loader addresses onto N_REG slave regions with timeout and sticky error capture.
module mem_region_router #(
  parameter int N_REG = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE = {32'hFFFF_0000, 32'h7000_0000, 32'h1001_0000, 32'h0040_0000},
  parameter logic [N_REG*ADDR_W-1:0] REG_LAST = {32'hFFFF_0080, 32'h7FFF_EFFC, 32'h6FFF_FFFF, 32'h0040_FFFF},
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic work_trig,
  input  logic load_trig,
  input  logic ld_wen,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic err_clr,
  output logic mode,
  output logic bus_err,
  output logic [ADDR_W-1:0] err_addr,
  mem_region_router_if.slave bus
);
  localparam int IW = N_REG > 1 ? $clog2(N_REG) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx, c_idx, l_idx;
  logic [ADDR_W-1:0] addr, off, c_off, l_off, err_a;
  logic [DATA_W-1:0] wdata, rdata, rd;
  logic [N_REG-1:0] oh;
  logic [7:0] cnt;
  logic we, ld_pulse, c_hit, l_hit, rdy, start, err_ev, ld_ok, to_load;
  // Scanning from the top index down lets the lowest matching region overwrite the result.
  function automatic logic [IW+ADDR_W:0] decode(input logic [ADDR_W-1:0] a);
    logic [IW+ADDR_W:0] r;
    r = '0;
    for (int i = N_REG - 1; i >= 0; i--)
      if (a >= REG_BASE[i*ADDR_W +: ADDR_W] && a <= REG_LAST[i*ADDR_W +: ADDR_W])
        r = {1'b1, IW'(i), a - REG_BASE[i*ADDR_W +: ADDR_W]};
    return r;
  endfunction
  assign {c_hit, c_idx, c_off} = decode(bus.cpu_addr);
  assign {l_hit, l_idx, l_off} = decode(ld_addr);
  always_comb begin
    rdy = 1'b0;
    rd = '0;
    oh = '0;
    for (int i = 0; i < N_REG; i++)
      if (idx == IW'(i)) begin
        rdy = bus.slv_ready[i];
        rd = bus.slv_rdata[i*DATA_W +: DATA_W];
        oh[i] = 1'b1;
      end
  end
  assign to_load = load_trig & ~work_trig;
  assign ld_ok = ~mode & ld_wen & l_hit;
  always_comb begin
    nxt = state;
    start = 1'b0;
    err_ev = 1'b0;
    err_a = bus.cpu_addr;
    case (state)
      IDLE:
        if (mode && bus.cpu_req && !to_load) begin
          nxt = c_hit ? ACCESS : DONE;
          start = c_hit;
          err_ev = ~c_hit;
        end else if (!mode && ld_wen && !l_hit) begin
          err_ev = 1'b1;
          err_a = ld_addr;
        end
      ACCESS:
        if (rdy) nxt = DONE;
        else if (cnt == 8'(TIMEOUT - 1)) begin
          nxt = DONE;
          err_ev = 1'b1;
          err_a = addr;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode <= 1'b1;
      cnt <= '0;
      idx <= '0;
      addr <= '0;
      off <= '0;
      we <= 1'b0;
      wdata <= '0;
      rdata <= '0;
      ld_pulse <= 1'b0;
      bus_err <= 1'b0;
      err_addr <= '0;
    end else begin
      mode <= (state == IDLE && (work_trig || load_trig)) ? work_trig : mode;
      cnt <= (state == ACCESS) ? cnt + 8'd1 : 8'd0;
      ld_pulse <= ld_ok;
      if (start) begin
        idx <= c_idx;
        addr <= bus.cpu_addr;
        off <= c_off;
        we <= bus.cpu_we;
        wdata <= bus.cpu_wdata;
      end else if (ld_ok) begin
        idx <= l_idx;
        addr <= ld_addr;
        off <= l_off;
        we <= 1'b1;
        wdata <= ld_wdata;
      end
      if (state == ACCESS && rdy && !we) rdata <= rd;
      else if (err_ev && mode) rdata <= '0;
      if (err_ev && (!bus_err || err_clr)) begin
        bus_err <= 1'b1;
        err_addr <= err_a;
      end else if (err_clr) bus_err <= 1'b0;
    end
  assign bus.cpu_stall = ~mode | (state == IDLE & bus.cpu_req) | (state == ACCESS);
  assign bus.cpu_rdata = rdata;
  assign bus.slv_sel = (state == ACCESS || ld_pulse) ? oh : '0;
  assign bus.slv_we = we;
  assign bus.slv_addr = off;
  assign bus.slv_wdata = wdata;
endmodule

// File: tb/tb_mem_region_router.sv
// tb_mem_region_router: directed vectors with hand-computed expectations for the region router.
module tb_mem_region_router;
  logic clk, rst_n, work_trig, load_trig, ld_wen, err_clr, mode, bus_err;
  logic [31:0] ld_addr, ld_wdata, err_addr;
  int vectors = 0;
  int miscompares = 0;
  mem_region_router_if #(.N_REG(4), .ADDR_W(32), .DATA_W(32)) bus ();
  mem_region_router dut (
    .clk(clk), .rst_n(rst_n), .work_trig(work_trig), .load_trig(load_trig),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .err_clr(err_clr),
    .mode(mode), .bus_err(bus_err), .err_addr(err_addr), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    vectors++; if (mode !== 1'b1) begin miscompares++; $display("FAIL rst_mode got %b want 1", mode); end
    vectors++; if (bus.slv_sel !== 4'b0000) begin miscompares++; $display("FAIL rst_sel got %b want 0000", bus.slv_sel); end
    vectors++; if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", bus.cpu_rdata); end
    vectors++; if (bus.slv_addr !== 32'h0 || bus.slv_wdata !== 32'h0 || bus.slv_we !== 1'b0) begin miscompares++; $display("FAIL rst_slv got %h/%h/%b want 0/0/0", bus.slv_addr, bus.slv_wdata, bus.slv_we); end
    vectors++; if (bus_err !== 1'b0 || err_addr !== 32'h0) begin miscompares++; $display("FAIL rst_err got %b/%h want 0/0", bus_err, err_addr); end
  endtask

  task automatic test_read;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h1001_0004;
    bus.slv_ready = 4'b0010; bus.slv_rdata[32 +: 32] = 32'hDEADBEEF;
    #1;
    vectors++; if (bus.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL rd_stall_t got %b want 1", bus.cpu_stall); end
    @(negedge clk);
    vectors++; if (bus.slv_sel !== 4'b0010) begin miscompares++; $display("FAIL rd_sel got %b want 0010", bus.slv_sel); end
    vectors++; if (bus.slv_addr !== 32'h4 || bus.slv_we !== 1'b0) begin miscompares++; $display("FAIL rd_addr got %h/%b want 4/0", bus.slv_addr, bus.slv_we); end
    @(negedge clk);
    vectors++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", bus.cpu_rdata); end
    vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rd_stall_t2 got %b want 0", bus.cpu_stall); end
    bus.cpu_req = 0; bus.slv_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_write;
    int n = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'hFFFF_0010; bus.cpu_wdata = 32'h1234_5678;
    bus.slv_ready = 0; bus.slv_rdata[96 +: 32] = 32'h9999_9999;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) bus.slv_ready = 4'b1000;
      #1;
      if (k == 1) begin
        vectors++; if (bus.slv_sel !== 4'b1000 || bus.slv_we !== 1'b1) begin miscompares++; $display("FAIL wr_sel got %b/%b want 1000/1", bus.slv_sel, bus.slv_we); end
        vectors++; if (bus.slv_addr !== 32'h10 || bus.slv_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_addr got %h/%h want 10/12345678", bus.slv_addr, bus.slv_wdata); end
      end
      if (!bus.cpu_stall) break;
      n++;
      @(negedge clk);
    end
    bus.cpu_req = 0; bus.slv_ready = 0;
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL wr_stall_cycles got %0d want 5", n); end
    vectors++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_rdata_hold got %h want deadbeef", bus.cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_unmapped;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h0800_0000;
    @(negedge clk);
    vectors++; if (bus.cpu_stall !== 1'b0 || bus.slv_sel !== 4'b0) begin miscompares++; $display("FAIL um_done got %b/%b want 0/0000", bus.cpu_stall, bus.slv_sel); end
    vectors++; if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL um_rdata got %h want 0", bus.cpu_rdata); end
    vectors++; if (bus_err !== 1'b1 || err_addr !== 32'h0800_0000) begin miscompares++; $display("FAIL um_err got %b/%h want 1/08000000", bus_err, err_addr); end
    bus.cpu_req = 0;
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL um_clr got %b want 0", bus_err); end
    bus.cpu_req = 1; bus.cpu_addr = 32'h0900_0000;
    @(negedge clk); bus.cpu_req = 0;
    @(negedge clk); bus.cpu_req = 1; bus.cpu_addr = 32'h0A00_0000;
    @(negedge clk); bus.cpu_req = 0;
    vectors++; if (bus_err !== 1'b1 || err_addr !== 32'h0900_0000) begin miscompares++; $display("FAIL um_sticky got %b/%h want 1/09000000", bus_err, err_addr); end
    @(negedge clk); bus.cpu_req = 1; bus.cpu_addr = 32'h0B00_0000; err_clr = 1;
    @(negedge clk); bus.cpu_req = 0; err_clr = 0;
    vectors++; if (bus_err !== 1'b1 || err_addr !== 32'h0B00_0000) begin miscompares++; $display("FAIL um_clr_race got %b/%h want 1/0b000000", bus_err, err_addr); end
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic test_boundary;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h7FFF_EFFC;
    bus.slv_ready = 4'b0100; bus.slv_rdata[64 +: 32] = 32'hCAFE_F00D;
    @(negedge clk);
    vectors++; if (bus.slv_sel !== 4'b0100 || bus.slv_addr !== 32'h0FFF_EFFC) begin miscompares++; $display("FAIL bd_r2_last got %b/%h want 0100/0fffeffc", bus.slv_sel, bus.slv_addr); end
    @(negedge clk); bus.cpu_req = 0; bus.slv_ready = 0;
    vectors++; if (bus.cpu_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL bd_r2_data got %h want cafef00d", bus.cpu_rdata); end
    @(negedge clk); bus.cpu_req = 1; bus.cpu_addr = 32'hFFFF_0080; bus.slv_ready = 4'b1000;
    @(negedge clk);
    vectors++; if (bus.slv_sel !== 4'b1000 || bus.slv_addr !== 32'h80) begin miscompares++; $display("FAIL bd_r3_last got %b/%h want 1000/80", bus.slv_sel, bus.slv_addr); end
    @(negedge clk); bus.cpu_req = 0; bus.slv_ready = 0;
    @(negedge clk); bus.cpu_req = 1; bus.cpu_addr = 32'h7FFF_F000;
    @(negedge clk); bus.cpu_req = 0;
    vectors++; if (bus_err !== 1'b1 || err_addr !== 32'h7FFF_F000 || bus.slv_sel !== 4'b0) begin miscompares++; $display("FAIL bd_past_r2 got %b/%h/%b want 1/7ffff000/0000", bus_err, err_addr, bus.slv_sel); end
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic test_timeout;
    int n = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h7000_0100; bus.slv_ready = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.slv_sel !== 4'b0100) break;
      n++;
    end
    bus.cpu_req = 0;
    vectors++; if (n !== 15) begin miscompares++; $display("FAIL to_cycles got %0d want 15", n); end
    vectors++; if (bus.cpu_rdata !== 32'h0 || bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL to_rdata got %h/%b want 0/0", bus.cpu_rdata, bus.cpu_stall); end
    vectors++; if (bus_err !== 1'b1 || err_addr !== 32'h7000_0100) begin miscompares++; $display("FAIL to_err got %b/%h want 1/70000100", bus_err, err_addr); end
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic test_back_to_back;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h0040_0010;
    bus.slv_ready = 4'b0001; bus.slv_rdata[0 +: 32] = 32'hAA;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.cpu_rdata !== 32'hAA || bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_first got %h/%b want aa/0", bus.cpu_rdata, bus.cpu_stall); end
    bus.cpu_addr = 32'h0040_0020; bus.slv_rdata[0 +: 32] = 32'hBB;
    @(negedge clk);
    vectors++; if (bus.cpu_stall !== 1'b1 || bus.slv_sel !== 4'b0) begin miscompares++; $display("FAIL b2b_idle got %b/%b want 1/0000", bus.cpu_stall, bus.slv_sel); end
    @(negedge clk);
    vectors++; if (bus.slv_sel !== 4'b0001 || bus.slv_addr !== 32'h20) begin miscompares++; $display("FAIL b2b_second got %b/%h want 0001/20", bus.slv_sel, bus.slv_addr); end
    @(negedge clk); bus.cpu_req = 0; bus.slv_ready = 0;
    vectors++; if (bus.cpu_rdata !== 32'hBB) begin miscompares++; $display("FAIL b2b_data got %h want bb", bus.cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_load;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h1001_0000; bus.slv_ready = 0;
    @(negedge clk); load_trig = 1;
    @(negedge clk); bus.slv_ready = 4'b0010;
    vectors++; if (mode !== 1'b1) begin miscompares++; $display("FAIL ld_defer_acc got %b want 1", mode); end
    @(negedge clk); bus.cpu_req = 0; bus.slv_ready = 0;
    vectors++; if (mode !== 1'b1) begin miscompares++; $display("FAIL ld_defer_done got %b want 1", mode); end
    @(negedge clk);
    vectors++; if (mode !== 1'b1) begin miscompares++; $display("FAIL ld_defer_idle got %b want 1", mode); end
    @(negedge clk); load_trig = 0;
    vectors++; if (mode !== 1'b0 || bus.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL ld_mode got %b/%b want 0/1", mode, bus.cpu_stall); end
    ld_wen = 1; ld_addr = 32'h0040_0008; ld_wdata = 32'hA5A5_0001;
    @(negedge clk); ld_wen = 0;
    vectors++; if (bus.slv_sel !== 4'b0001 || bus.slv_addr !== 32'h8 || bus.slv_we !== 1'b1) begin miscompares++; $display("FAIL ld_wr got %b/%h/%b want 0001/8/1", bus.slv_sel, bus.slv_addr, bus.slv_we); end
    vectors++; if (bus.slv_wdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL ld_wdata got %h want a5a50001", bus.slv_wdata); end
    @(negedge clk);
    vectors++; if (bus.slv_sel !== 4'b0) begin miscompares++; $display("FAIL ld_one_cycle got %b want 0000", bus.slv_sel); end
    ld_wen = 1; ld_addr = 32'h0800_0004;
    @(negedge clk); ld_wen = 0;
    vectors++; if (bus_err !== 1'b1 || err_addr !== 32'h0800_0004 || bus.slv_sel !== 4'b0) begin miscompares++; $display("FAIL ld_unmapped got %b/%h/%b want 1/08000004/0000", bus_err, err_addr, bus.slv_sel); end
    bus.cpu_req = 1; bus.cpu_addr = 32'h0040_0000;
    @(negedge clk); bus.cpu_req = 0;
    vectors++; if (bus.slv_sel !== 4'b0 || mode !== 1'b0) begin miscompares++; $display("FAIL ld_cpu_ignored got %b/%b want 0000/0", bus.slv_sel, mode); end
    work_trig = 1; load_trig = 1;
    @(negedge clk); work_trig = 0; load_trig = 0;
    vectors++; if (mode !== 1'b1) begin miscompares++; $display("FAIL ld_work_prio got %b want 1", mode); end
    err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic test_reset_mid;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h0C00_0000;
    @(negedge clk); bus.cpu_req = 0;
    @(negedge clk); bus.cpu_req = 1; bus.cpu_addr = 32'h0040_0004;
    bus.slv_ready = 4'b0001; bus.slv_rdata[0 +: 32] = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk); bus.cpu_req = 0; bus.slv_ready = 0;
    @(negedge clk); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'hFFFF_0004; bus.cpu_wdata = 32'h77;
    @(negedge clk);
    vectors++; if (bus.slv_sel !== 4'b1000 || bus_err !== 1'b1 || bus.cpu_rdata !== 32'h1111_2222) begin miscompares++; $display("FAIL rm_pre got %b/%b/%h want 1000/1/11112222", bus.slv_sel, bus_err, bus.cpu_rdata); end
    #2 rst_n = 0; bus.cpu_req = 0;
    #1;
    vectors++; if (bus.slv_sel !== 4'b0 || bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rm_sel got %b/%b want 0000/0", bus.slv_sel, bus.cpu_stall); end
    vectors++; if (bus.slv_we !== 1'b0 || bus.slv_addr !== 32'h0 || bus.slv_wdata !== 32'h0) begin miscompares++; $display("FAIL rm_slv got %b/%h/%h want 0/0/0", bus.slv_we, bus.slv_addr, bus.slv_wdata); end
    vectors++; if (bus.cpu_rdata !== 32'h0 || mode !== 1'b1) begin miscompares++; $display("FAIL rm_rdata got %h/%b want 0/1", bus.cpu_rdata, mode); end
    vectors++; if (bus_err !== 1'b0 || err_addr !== 32'h0) begin miscompares++; $display("FAIL rm_err got %b/%h want 0/0", bus_err, err_addr); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1; work_trig = 0; load_trig = 0; ld_wen = 0; ld_addr = 0; ld_wdata = 0; err_clr = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.slv_rdata = '0; bus.slv_ready = 0;
    #1 rst_n = 0;
    #2;
    test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_read;
    test_write;
    test_unmapped;
    test_boundary;
    test_timeout;
    test_back_to_back;
    test_load;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
